lc3_fetch_ctrl: RTL and testbench

LC3_FETCH_CTRL -- requirements
Module: lc3_fetch_ctrl

---
 rtl/lc3_fetch_ctrl_pkg.sv | 16 +
 rtl/lc3_fetch_ctrl_if.sv | 23 ++
 rtl/lc3_pc_next_sel.sv | 31 +++
 rtl/lc3_fetch_ctrl.sv | 91 +++++++++
 tb/tb_lc3_fetch_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/lc3_fetch_ctrl_pkg.sv
// Shared types and constants for the LC-3 instruction fetch controller.
package lc3_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        FETCH    = 2'd1,
        WAIT_MEM = 2'd2
    } fetch_state_t;

    localparam logic [15:0] LC3_RESET_PC = 16'h3000;

    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/lc3_fetch_ctrl_if.sv
// Pipeline-facing bundle of the fetch controller: enables, redirect, memory handshake and fetch status.
interface lc3_fetch_ctrl_if;
    logic        enable_fetch;
    logic        enable_updatePC;
    logic        br_taken;
    logic [15:0] taddr;
    logic        imem_ready;
    logic [15:0] pc;
    logic [15:0] npc;
    logic        Imem_rd;
    logic        fetch_valid;
    logic [15:0] fetch_count;

    modport master (
        output enable_fetch, enable_updatePC, br_taken, taddr, imem_ready,
        input  pc, npc, Imem_rd, fetch_valid, fetch_count
    );

    modport slave (
        input  enable_fetch, enable_updatePC, br_taken, taddr, imem_ready,
        output pc, npc, Imem_rd, fetch_valid, fetch_count
    );
endinterface

// File: rtl/lc3_pc_next_sel.sv
// Next-PC priority mux: live branch, then deferred redirect, then sequential advance, else hold.
module lc3_pc_next_sel (
    input  logic        i_enable_updatePC,
    input  logic        i_br_taken,
    input  logic [15:0] i_taddr,
    input  logic        i_redirect_pending,
    input  logic [15:0] i_redirect_addr,
    input  logic        i_fetch_done,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_npc,
    output logic [15:0] o_pc_next,
    output logic        o_redirect
);

    always_comb begin
        o_pc_next  = i_pc;
        o_redirect = 1'b0;
        if (i_enable_updatePC) begin
            if (i_br_taken) begin
                o_pc_next  = i_taddr;
                o_redirect = 1'b1;
            end else if (i_redirect_pending) begin
                o_pc_next  = i_redirect_addr;
                o_redirect = 1'b1;
            end else if (i_fetch_done) begin
                o_pc_next  = i_npc;
            end
        end
    end

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 fetch controller: owns the PC, drives the instruction memory read and counts completed fetches.
module lc3_fetch_ctrl
    import lc3_fetch_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_PC = LC3_RESET_PC
) (
    input  logic          clock,
    input  logic          reset,
    lc3_fetch_ctrl_if.slave bus
);

    fetch_state_t r_state;
    logic [15:0]  r_pc;
    logic         r_redirect_pending;
    logic [15:0]  r_redirect_addr;
    logic         r_fetch_valid;
    logic [15:0]  r_fetch_count;

    logic [15:0]  w_npc;
    logic         w_imem_rd;
    logic         w_fetch_done;
    logic [15:0]  w_pc_next;
    logic         w_redirect;
    logic         w_fetch_kept;

    assign w_npc        = pc_inc(r_pc);
    assign w_imem_rd    = ((r_state == FETCH) && bus.enable_fetch) || (r_state == WAIT_MEM);
    assign w_fetch_done = w_imem_rd && bus.imem_ready;
    // A fetch landing in the same cycle as a redirect fetched the wrong path.
    assign w_fetch_kept = w_fetch_done && !w_redirect;

    lc3_pc_next_sel u_pc_next_sel (
        .i_enable_updatePC  (bus.enable_updatePC),
        .i_br_taken         (bus.br_taken),
        .i_taddr            (bus.taddr),
        .i_redirect_pending (r_redirect_pending),
        .i_redirect_addr    (r_redirect_addr),
        .i_fetch_done       (w_fetch_done),
        .i_pc               (r_pc),
        .i_npc              (w_npc),
        .o_pc_next          (w_pc_next),
        .o_redirect         (w_redirect)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state            <= RST_HOLD;
            r_pc               <= RESET_PC;
            r_redirect_pending <= 1'b0;
            r_redirect_addr    <= 16'h0000;
            r_fetch_valid      <= 1'b0;
            r_fetch_count      <= 16'h0000;
        end else begin
            r_pc          <= w_pc_next;
            r_fetch_valid <= w_fetch_kept;
            if (w_fetch_kept) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end

            // Branches that arrive while the PC is frozen are remembered until it may move.
            if (bus.br_taken && !bus.enable_updatePC) begin
                r_redirect_pending <= 1'b1;
                r_redirect_addr    <= bus.taddr;
            end else if (w_redirect) begin
                r_redirect_pending <= 1'b0;
            end

            case (r_state)
                RST_HOLD: r_state <= FETCH;
                FETCH: begin
                    if (!w_redirect && w_imem_rd && !bus.imem_ready) begin
                        r_state <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (w_redirect || bus.imem_ready) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= RST_HOLD;
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.npc         = w_npc;
    assign bus.Imem_rd     = w_imem_rd;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Scoreboard bench for lc3_fetch_ctrl: directed scenarios plus random traffic against a cycle-level reference model.
module tb_lc3_fetch_ctrl;

    logic clock = 1'b0;
    logic reset;

    lc3_fetch_ctrl_if bus ();

    lc3_fetch_ctrl #(.RESET_PC(16'h3000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [15:0] pc;
        logic [15:0] npc;
        logic        rd;
        logic        fv;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    // Reference model: what the fetch unit is known to be doing after each edge.
    bit          m_known   = 0;
    bit          m_started = 0;
    bit          m_waiting = 0;
    logic [15:0] m_pc      = 16'h3000;
    bit          m_pend    = 0;
    logic [15:0] m_raddr   = 16'h0000;
    bit          m_valid   = 0;
    logic [15:0] m_count   = 16'h0000;

    task automatic chk(input string nm, input int c, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
        end
    endtask

    // One clock of stimulus: drive inputs, record what the outputs must show this cycle, advance the model.
    task automatic cyc(input bit rst_n, input bit ef, input bit eu, input bit br,
                       input logic [15:0] ta, input bit rdy);
        exp_t e;
        bit   rd, done, redir;
        @(negedge clock);
        reset               = rst_n;
        bus.enable_fetch    = ef;
        bus.enable_updatePC = eu;
        bus.br_taken        = br;
        bus.taddr           = ta;
        bus.imem_ready      = rdy;
        cyc_no++;

        rd = m_started && (m_waiting || ef);
        if (m_known) begin
            e.cyc = cyc_no;
            e.pc  = m_pc;
            e.npc = m_pc + 16'd1;
            e.rd  = rd;
            e.fv  = m_valid;
            e.cnt = m_count;
            q.push_back(e);
        end

        if (!rst_n) begin
            m_known = 1; m_started = 0; m_waiting = 0; m_pc = 16'h3000;
            m_pend = 0; m_raddr = 16'h0000; m_valid = 0; m_count = 16'h0000;
        end else if (m_known) begin
            done  = rd && rdy;
            redir = eu && (br || m_pend);
            m_valid = done && !redir;
            if (m_valid) m_count = m_count + 16'd1;
            if (eu) begin
                if (br)          m_pc = ta;
                else if (m_pend) m_pc = m_raddr;
                else if (done)   m_pc = m_pc + 16'd1;
            end
            if (br && !eu) begin
                m_pend = 1; m_raddr = ta;
            end else if (redir) begin
                m_pend = 0;
            end
            if (!m_started) begin
                m_started = 1; m_waiting = 0;
            end else begin
                m_waiting = !redir && rd && !rdy;
            end
        end
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, 0, 16'h0000, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",          e.cyc, bus.pc,                   e.pc);
                chk("npc",         e.cyc, bus.npc,                  e.npc);
                chk("Imem_rd",     e.cyc, {15'd0, bus.Imem_rd},     {15'd0, e.rd});
                chk("fetch_valid", e.cyc, {15'd0, bus.fetch_valid}, {15'd0, e.fv});
                chk("fetch_count", e.cyc, bus.fetch_count,          e.cnt);
            end
        end
    end

    initial begin : stimulus
        bit rst_n, ef, eu, br, rdy;
        logic [15:0] ta;

        // Reset held three cycles, then release into a four-fetch stream.
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 16'h0000, 1);
        cyc(1, 1, 1, 0, 16'h0000, 1);
        stream(4);
        stream(1);

        // Memory stall at 3005.
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 16'h0000, 0);
        cyc(1, 0, 1, 0, 16'h0000, 1);
        stream(2);

        // Branch while PC frozen, applied two cycles later with a fetch completing.
        cyc(1, 1, 0, 1, 16'h4000, 1);
        cyc(1, 1, 0, 0, 16'h0000, 1);
        cyc(1, 1, 1, 0, 16'h0000, 1);
        stream(3);

        // Live branch overwriting a pending one, then redirect abandoning a stall.
        cyc(1, 1, 0, 1, 16'h5000, 0);
        cyc(1, 0, 0, 1, 16'h5100, 0);
        cyc(1, 0, 1, 0, 16'h0000, 0);
        stream(2);

        // PC wrap from FFFF.
        cyc(1, 1, 1, 1, 16'hFFFF, 1);
        stream(3);

        // Reset during a stall with a pending redirect.
        cyc(1, 1, 1, 0, 16'h0000, 0);
        cyc(1, 1, 0, 1, 16'h6000, 0);
        cyc(0, 1, 0, 0, 16'h0000, 0);
        cyc(1, 1, 1, 0, 16'h0000, 1);
        stream(3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            ef    = ($urandom_range(0, 99) < 80);
            eu    = ($urandom_range(0, 99) < 70);
            br    = ($urandom_range(0, 99) < 10);
            rdy   = ($urandom_range(0, 99) < 65);
            ta    = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                : 16'($urandom);
            cyc(rst_n, ef, eu, br, ta, rdy);
        end

        // Fetch counter wrap: 65537 fetches from a fresh reset.
        cyc(0, 1, 1, 0, 16'h0000, 1);
        cyc(1, 1, 1, 0, 16'h0000, 1);
        stream(65537);
        stream(2);

        @(negedge clock);
        #6;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d want=0 entries left", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
